// File: rtl/video_mode_ctrl.sv
// Mode sequencer for the 74.25 MHz HDMI timing generator: holds a three-entry
// CEA mode table, accepts mode requests over valid/ready, switches at a frame
// boundary and keeps video gated until the new timing has settled.
module video_mode_ctrl #(
    parameter int unsigned DEFAULT_MODE   = 0,
    parameter int unsigned GEN_RST_CYCLES = 16,
    parameter int unsigned SETTLE_FRAMES  = 2,
    parameter int unsigned VSYNC_TIMEOUT  = 3000000
) (
    input  logic        i_pixel_clock,
    input  logic        i_reset_n,
    input  logic        i_mode_req_valid,
    input  logic [1:0]  i_mode_req_id,
    output logic        o_mode_req_ready,
    output logic        o_mode_err,
    output logic [1:0]  o_cur_mode,
    output logic        o_gen_reset,
    output logic        o_video_enable,
    input  logic        i_vsync_in,
    output logic [11:0] o_h_active,
    output logic [11:0] o_h_fp,
    output logic [11:0] o_h_sync,
    output logic [11:0] o_h_bp,
    output logic [11:0] o_v_active,
    output logic [11:0] o_v_fp,
    output logic [11:0] o_v_sync,
    output logic [11:0] o_v_bp
);

    localparam logic [1:0]  DefModeId   = 2'(DEFAULT_MODE);
    localparam logic [1:0]  InvalidId   = 2'd3;
    localparam logic [21:0] LoadLast    = 22'(GEN_RST_CYCLES - 1);
    localparam logic [21:0] SettleLast  = 22'(SETTLE_FRAMES - 1);
    localparam logic [21:0] TimeoutLast = 22'(VSYNC_TIMEOUT - 1);

    typedef enum logic [1:0] {
        StLoad,
        StSettle,
        StRun,
        StWaitVsync
    } state_e;

    // Packed as {h_active, h_fp, h_sync, h_bp, v_active, v_fp, v_sync, v_bp}.
    function automatic logic [95:0] mode_timing(input logic [1:0] id);
        logic [95:0] t;
        case (id)
            2'd1:    t = {12'd1280, 12'd440, 12'd40, 12'd220, 12'd720,  12'd5, 12'd5, 12'd20};
            2'd2:    t = {12'd1920, 12'd88,  12'd44, 12'd148, 12'd1080, 12'd4, 12'd5, 12'd36};
            default: t = {12'd1280, 12'd110, 12'd40, 12'd220, 12'd720,  12'd5, 12'd5, 12'd20};
        endcase
        return t;
    endfunction

    state_e      r_state;
    logic [21:0] r_cnt;           // load cycles, settle frames or vsync timeout
    logic        r_settle_first;  // marks the SETTLE entry cycle
    logic [1:0]  r_cur_mode;
    logic [1:0]  r_pending_mode;
    logic [95:0] r_timing;
    logic        r_gen_reset;
    logic        r_video_enable;
    logic        r_ready;
    logic        r_mode_err;
    logic        r_vs_q;
    logic        w_rise;

    assign w_rise = i_vsync_in & ~r_vs_q;

    // Register vsync for rising-edge detection.
    always_ff @(posedge i_pixel_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_vs_q <= 1'b0;
        end else begin
            r_vs_q <= i_vsync_in;
        end
    end

    // Mode sequencer FSM with all outputs registered.
    always_ff @(posedge i_pixel_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state        <= StLoad;
            r_cnt          <= '0;
            r_settle_first <= 1'b0;
            r_cur_mode     <= DefModeId;
            r_pending_mode <= DefModeId;
            r_timing       <= mode_timing(DefModeId);
            r_gen_reset    <= 1'b1;
            r_video_enable <= 1'b0;
            r_ready        <= 1'b0;
            r_mode_err     <= 1'b0;
        end else begin
            r_mode_err <= 1'b0;
            case (r_state)
                StLoad: begin
                    if (r_cnt == LoadLast) begin
                        r_state        <= StSettle;
                        r_cnt          <= '0;
                        r_gen_reset    <= 1'b0;
                        r_settle_first <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 22'd1;
                    end
                end
                StSettle: begin
                    r_settle_first <= 1'b0;
                    // A rise on the entry cycle belongs to the old timing.
                    if (w_rise && !r_settle_first) begin
                        if (r_cnt == SettleLast) begin
                            r_state        <= StRun;
                            r_video_enable <= 1'b1;
                            r_ready        <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + 22'd1;
                        end
                    end
                end
                StRun: begin
                    if (i_mode_req_valid && r_ready) begin
                        if (i_mode_req_id == InvalidId) begin
                            r_mode_err <= 1'b1;
                        end else if (i_mode_req_id != r_cur_mode) begin
                            r_pending_mode <= i_mode_req_id;
                            r_ready        <= 1'b0;
                            r_cnt          <= '0;
                            r_state        <= StWaitVsync;
                        end
                    end
                end
                StWaitVsync: begin
                    // Rise and timeout together still make one transition.
                    if (w_rise || (r_cnt == TimeoutLast)) begin
                        r_state        <= StLoad;
                        r_cnt          <= '0;
                        r_video_enable <= 1'b0;
                        r_cur_mode     <= r_pending_mode;
                        r_timing       <= mode_timing(r_pending_mode);
                        r_gen_reset    <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 22'd1;
                    end
                end
                default: begin
                    r_state <= StLoad;
                end
            endcase
        end
    end

    assign o_mode_req_ready = r_ready;
    assign o_mode_err       = r_mode_err;
    assign o_cur_mode       = r_cur_mode;
    assign o_gen_reset      = r_gen_reset;
    assign o_video_enable   = r_video_enable;
    assign o_h_active       = r_timing[95:84];
    assign o_h_fp           = r_timing[83:72];
    assign o_h_sync         = r_timing[71:60];
    assign o_h_bp           = r_timing[59:48];
    assign o_v_active       = r_timing[47:36];
    assign o_v_fp           = r_timing[35:24];
    assign o_v_sync         = r_timing[23:12];
    assign o_v_bp           = r_timing[11:0];

endmodule

// File: tb/tb_video_mode_ctrl.sv
// Scoreboard bench for video_mode_ctrl: stimulus pushes the expected output
// vector and the cycle it should appear on; a monitor pops one entry on every
// change of the DUT outputs.
module tb_video_mode_ctrl;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic [1:0]  req_id;
    logic        req_ready;
    logic        mode_err;
    logic [1:0]  cur_mode;
    logic        gen_reset;
    logic        video_enable;
    logic        vsync;
    logic [11:0] h_active, h_fp, h_sync, h_bp;
    logic [11:0] v_active, v_fp, v_sync, v_bp;

    video_mode_ctrl #(
        .DEFAULT_MODE  (0),
        .GEN_RST_CYCLES(4),
        .SETTLE_FRAMES (2),
        .VSYNC_TIMEOUT (50)
    ) u_dut (
        .i_pixel_clock   (clk),
        .i_reset_n       (rst_n),
        .i_mode_req_valid(req_valid),
        .i_mode_req_id   (req_id),
        .o_mode_req_ready(req_ready),
        .o_mode_err      (mode_err),
        .o_cur_mode      (cur_mode),
        .o_gen_reset     (gen_reset),
        .o_video_enable  (video_enable),
        .i_vsync_in      (vsync),
        .o_h_active      (h_active),
        .o_h_fp          (h_fp),
        .o_h_sync        (h_sync),
        .o_h_bp          (h_bp),
        .o_v_active      (v_active),
        .o_v_fp          (v_fp),
        .o_v_sync        (v_sync),
        .o_v_bp          (v_bp)
    );

    typedef struct {
        logic [101:0] v;
        int           c;
        string        name;
    } exp_t;

    exp_t         exp_q[$];
    int           n_checks = 0;
    int           n_fail   = 0;
    int           cyc      = 0;
    logic         vs_en;
    logic [101:0] w_outs;
    logic [101:0] mon_prev;
    bit           mon_first = 1'b1;

    assign w_outs = {gen_reset, video_enable, req_ready, mode_err, cur_mode,
                     h_active, h_fp, h_sync, h_bp, v_active, v_fp, v_sync, v_bp};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Posedge count; read at negedges it is the number of the last edge.
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [95:0] tbl(input logic [1:0] m);
        case (m)
            2'd0:    return {12'd1280, 12'd110, 12'd40, 12'd220, 12'd720,  12'd5, 12'd5, 12'd20};
            2'd1:    return {12'd1280, 12'd440, 12'd40, 12'd220, 12'd720,  12'd5, 12'd5, 12'd20};
            default: return {12'd1920, 12'd88,  12'd44, 12'd148, 12'd1080, 12'd4, 12'd5, 12'd36};
        endcase
    endfunction

    function automatic logic [101:0] vec(input logic gr, input logic ve, input logic rdy,
                                         input logic err, input logic [1:0] m);
        return {gr, ve, rdy, err, m, tbl(m)};
    endfunction

    task automatic push(input logic [101:0] v, input int c, input string name);
        exp_t e;
        e.v    = v;
        e.c    = c;
        e.name = name;
        exp_q.push_back(e);
    endtask

    task automatic at_cyc(input int c);
        @(negedge clk);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic req(input logic [1:0] id);
        req_valid = 1'b1;
        req_id    = id;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    // Vsync high for 5 cycles every 100; DUT sees the rise at edges 100k+51.
    initial begin
        vsync = 1'b0;
        forever begin
            @(negedge clk);
            vsync = vs_en && ((cyc % 100) >= 50) && ((cyc % 100) < 55);
        end
    end

    // Monitor: every output change consumes one scoreboard entry.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (mon_first || (w_outs !== mon_prev)) begin
                mon_first = 1'b0;
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_change: outputs %h at cycle %0d, no change expected",
                             w_outs, cyc);
                end else begin
                    e = exp_q.pop_front();
                    if ((w_outs !== e.v) || (cyc != e.c)) begin
                        n_fail++;
                        $display("FAIL %s: got %h at cycle %0d, want %h at cycle %0d",
                                 e.name, w_outs, cyc, e.v, e.c);
                    end
                end
                mon_prev = w_outs;
            end
        end
    end

    initial begin
        rst_n     = 1'b1;
        req_valid = 1'b0;
        req_id    = 2'd0;
        vs_en     = 1'b1;
        push(vec(1, 0, 0, 0, 2'd0), 1, "reset_state");
        #1 rst_n = 1'b0;

        // Test 1: release, gen_reset high 4 cycles, RUN after the 2nd rise.
        at_cyc(3);
        push(vec(0, 0, 0, 0, 2'd0), 7, "t1_gen_reset_low");
        push(vec(0, 1, 1, 0, 2'd0), 151, "t1_run_entry");
        rst_n = 1'b1;

        // Test 3: request current mode, no output change at all.
        at_cyc(160);
        req(2'd0);

        // Test 4: invalid id gives a one-cycle error pulse.
        at_cyc(170);
        push(vec(0, 1, 1, 1, 2'd0), 171, "t4_err_high");
        push(vec(0, 1, 1, 0, 2'd0), 172, "t4_err_low");
        req(2'd3);

        // Test 2: switch to 1080p30 at the next vsync rise.
        at_cyc(220);
        push(vec(0, 1, 0, 0, 2'd0), 221, "t2_ready_drop");
        push(vec(1, 0, 0, 0, 2'd2), 251, "t2_load_mode2");
        push(vec(0, 0, 0, 0, 2'd2), 255, "t2_gen_reset_low");
        push(vec(0, 1, 1, 0, 2'd2), 451, "t2_run_entry");
        req(2'd2);
        // A request while ready is low must be ignored.
        at_cyc(230);
        req(2'd1);

        // Test 5: vsync held low, switch forced by the 50-cycle timeout.
        at_cyc(460);
        vs_en = 1'b0;
        at_cyc(470);
        push(vec(0, 1, 0, 0, 2'd2), 471, "t5_ready_drop");
        push(vec(1, 0, 0, 0, 2'd1), 521, "t5_timeout_load");
        push(vec(0, 0, 0, 0, 2'd1), 525, "t5_gen_reset_low");
        push(vec(0, 1, 1, 0, 2'd1), 651, "t5_run_entry");
        req(2'd1);
        at_cyc(530);
        vs_en = 1'b1;

        // Test 6: reset during SETTLE of a switch to mode 2.
        at_cyc(720);
        push(vec(0, 1, 0, 0, 2'd1), 721, "t6_ready_drop");
        push(vec(1, 0, 0, 0, 2'd2), 751, "t6_load_mode2");
        push(vec(0, 0, 0, 0, 2'd2), 755, "t6_gen_reset_low");
        req(2'd2);
        at_cyc(800);
        push(vec(1, 0, 0, 0, 2'd0), 801, "t6_reset_state");
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (w_outs !== vec(1, 0, 0, 0, 2'd0)) begin
            n_fail++;
            $display("FAIL t6_async_reset: got %h, want %h", w_outs, vec(1, 0, 0, 0, 2'd0));
        end
        // Release so SETTLE entry coincides with a rise, which must not count.
        at_cyc(846);
        push(vec(0, 0, 0, 0, 2'd0), 850, "t6_gen_reset_low");
        push(vec(0, 1, 1, 0, 2'd0), 1051, "t6_run_entry");
        rst_n = 1'b1;

        at_cyc(1060);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, want 0 (next %s)",
                     exp_q.size(), exp_q[0].name);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
